cia_tod_seq: RTL and testbench
==============================

// Module: cia_tod_seq
// PURPOSE
//  Sequencer and arbiter for the CIA TOD (timer D) register port. It serves two
//  24-bit requesters (req0: RTC/host sync engine, req1: debug/OSD) and turns each
//  request into an ordered byte-access burst on the tlo/tme/thi/tcr port.
//  Read = latched HI,MID,LO. Write TOD = HI,MID,LO, so counting restarts on LO.
//  Alarm writes are bracketed by CRB7 set and clear. Bursts only use free bus cycles.
// PARAMETERS
//  STEP_GAP   0  idle clk7_en-qualified cycles inserted between burst steps (0..15)
//  FIX_PRIO   0  requester that wins simultaneous requests when round-robin is off
// PORTS
//  clk        in   1   system clock
//  reset      in   1   synchronous, active-high reset
//  clk7_en    in   1   clock enable; all state advances only when high
//  bus_busy   in   1   CPU owns the CIA port this cycle; sequencer must not drive
//  req_vld    in   2   per-requester request valid; held until ack
//  req_op     in   4   {op1[1:0],op0[1:0]}: 00 read TOD, 01 write TOD, 10 write alarm, 11 rsvd (treated as read)
//  req_wdata  in   48  {wdata1,wdata0}, 24 bits each
//  req_ack    out  2   one-cycle pulse (clk7_en-qualified) on the burst's final step
//  rdata      out  24  read result; valid with ack of a read, held until next read completes
//  tod_sel    out  1   high during any driven step; steers the CIA port mux to the sequencer
//  tod_wr     out  1   port write strobe (0 = read)
//  tod_tlo/tod_tme/tod_thi/tod_tcr  out 1 each  one-hot register select
//  tod_wdata  out  8   byte to timer
//  tod_rdata  in   8   byte from timer (combinational, same cycle as select)
// BEHAVIOUR
//  - Reset: FSM=IDLE, all outputs 0, rdata=0, RR pointer=0, gap counter=0.
//  - An active step is a cycle with clk7_en=1, bus_busy=0 and gap counter=0.
//    Selects are asserted only in active steps; otherwise they are 0 and the FSM holds.
//  - IDLE: on an enable cycle with any req_vld, latch winner id, op and wdata, then go to the first step.
//    Only IDLE arbitrates; the grant is fixed for the whole burst.
//  - READ: RD_HI(thi) -> RD_MID(tme) -> RD_LO(tlo). tod_rdata is captured into a shadow
//    register each step. rdata is updated and ack pulses in RD_LO.
//  - WRITE TOD: W_CR(tcr, data 8'h00) -> W_HI -> W_MID -> W_LO. Ack in W_LO.
//  - WRITE ALARM: A_CR1(tcr, 8'h80) -> A_HI -> A_MID -> A_LO -> A_CR0(tcr, 8'h00). Ack in A_CR0.
//    The burst must never end with CRB7=1.
//  - Every step after the last returns to IDLE. Back-to-back requests cost at least 1 IDLE enable cycle.
//  - STEP_GAP: the gap counter loads STEP_GAP after each active step and decrements on
//    clk7_en cycles. It does not load after the final step.
//  - bus_busy mid-burst pauses the burst; sequence, latched data and grant are preserved.
//    The TOD latch stays frozen between HI and LO, so the read remains coherent.
//  - req_vld dropped mid-burst: the burst completes and ack is still pulsed (ignored upstream).
//  - Reset mid-burst: immediate return to IDLE, no ack. The timer also resets, so CRB7 is cleared.
//  - tod_wdata = 0 on read steps.
// CONFIGURATION
//  CIA_TOD_SEQ_RR_EN defined: round-robin arbitration. Pointer flips to the other
//    requester on each grant. On a tie, the requester indicated by the pointer wins.
//  CIA_TOD_SEQ_RR_EN undefined: fixed priority; FIX_PRIO wins ties, no pointer register.
// STRUCTURE
//  - cia_tod_defs.vh: op encodings (OP_RD, OP_WR, OP_AL), FSM state localparams,
//    CR_ALARM=8'h80 and CR_TOD=8'h00. Shared with the CIA top-level port mux.
//  - Sub-module cia_tod_arb: 2-way arbiter (priority/RR, macro-controlled).
//    Outputs grant id and grant-valid.
//  - cia_tod_seq: step FSM, gap counter, data latch, read shadow.
// TESTING
//  1 Read, idle bus: TOD=24'h12_34_56, req0 read -> thi,tme,tlo on 3 consecutive enable cycles; ack0; rdata=123456.
//  2 Write TOD: req1 wr 24'hAB_CD_EF -> tcr(00), thi(AB), tme(CD), tlo(EF); timer counts from ABCDEF after ack.
//  3 Write alarm: req0 24'h00_00_05, TOD from 0 -> tcr(80),3 bytes,tcr(00); timer irq when TOD=5; CRB7=0 at end.
//  4 Tie with both valid, RR_EN defined: grants 0,1,0,1 over four requests. Undefined, FIX_PRIO=1: 1,1,1 until req1 drops.
//  5 bus_busy high 3 cycles between RD_MID and RD_LO while TOD increments -> rdata equals value at RD_HI; no select during busy.
//  6 STEP_GAP=2: 2 idle enable cycles between selects. Reset asserted in W_MID -> IDLE, no ack, outputs 0 next cycle.

Source files
------------

// File: rtl/cia_tod_seq_pkg.sv
// Shared definitions for the CIA TOD sequencer: op codes, step states, CRB values.
package cia_tod_seq_pkg;

  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_AL = 2'b10;

  localparam logic [7:0] CR_ALARM = 8'h80;
  localparam logic [7:0] CR_TOD   = 8'h00;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_RD_HI  = 4'd1;
  localparam logic [3:0] ST_RD_MID = 4'd2;
  localparam logic [3:0] ST_RD_LO  = 4'd3;
  localparam logic [3:0] ST_W_CR   = 4'd4;
  localparam logic [3:0] ST_W_HI   = 4'd5;
  localparam logic [3:0] ST_W_MID  = 4'd6;
  localparam logic [3:0] ST_W_LO   = 4'd7;
  localparam logic [3:0] ST_A_CR1  = 4'd8;
  localparam logic [3:0] ST_A_HI   = 4'd9;
  localparam logic [3:0] ST_A_MID  = 4'd10;
  localparam logic [3:0] ST_A_LO   = 4'd11;
  localparam logic [3:0] ST_A_CR0  = 4'd12;

  typedef struct packed {
    logic        id;
    logic [23:0] wdata;
  } tod_req_t;

  function automatic logic is_final(input logic [3:0] st);
    return (st == ST_RD_LO) || (st == ST_W_LO) || (st == ST_A_CR0);
  endfunction

endpackage

// File: rtl/cia_tod_arb.sv
// Two-way requester arbiter for the TOD sequencer.
// CIA_TOD_SEQ_RR_EN selects round-robin; otherwise FIX_PRIO wins ties.
module cia_tod_arb #(
  parameter int FIX_PRIO = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_vld,
  input  logic       grant_en,
  output logic       gnt_id,
  output logic       gnt_vld
);

  assign gnt_vld = |req_vld;

`ifdef CIA_TOD_SEQ_RR_EN
  logic ptr_q;

  assign gnt_id = (&req_vld) ? ptr_q : req_vld[1];

  // Pointer moves to the requester that just lost the grant
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else if (grant_en && gnt_vld) begin
      ptr_q <= ~gnt_id;
    end
  end
`else
  localparam logic PRIO = (FIX_PRIO != 0);
  logic unused_ok;

  assign gnt_id    = (&req_vld) ? PRIO : req_vld[1];
  assign unused_ok = clk ^ reset ^ grant_en;
`endif

endmodule

// File: rtl/cia_tod_seq.sv
// CIA TOD register-port sequencer: arbitrates two 24-bit requesters and issues byte bursts.
// Round-robin arbitration is enabled by defining CIA_TOD_SEQ_RR_EN.
module cia_tod_seq
  import cia_tod_seq_pkg::*;
#(
  parameter int STEP_GAP = 0,
  parameter int FIX_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk7_en,
  input  logic        bus_busy,
  input  logic [1:0]  req_vld,
  input  logic [3:0]  req_op,
  input  logic [47:0] req_wdata,
  output logic [1:0]  req_ack,
  output logic [23:0] rdata,
  output logic        tod_sel,
  output logic        tod_wr,
  output logic        tod_tlo,
  output logic        tod_tme,
  output logic        tod_thi,
  output logic        tod_tcr,
  output logic [7:0]  tod_wdata,
  input  logic [7:0]  tod_rdata
);

  logic [3:0]  state_q, state_d;
  logic [3:0]  gap_q, gap_d;
  logic [23:0] rdata_q;
  logic [15:0] shadow_q;
  tod_req_t    req_q;
  logic        gnt_id, gnt_vld;
  logic        grant_take, active;
  logic [1:0]  win_op;

  assign grant_take = clk7_en && (state_q == ST_IDLE) && gnt_vld;
  assign active     = clk7_en && !bus_busy && (gap_q == 4'd0) && (state_q != ST_IDLE);
  assign win_op     = gnt_id ? req_op[3:2] : req_op[1:0];

  cia_tod_arb #(.FIX_PRIO(FIX_PRIO)) u_arb (
    .clk      (clk),
    .reset    (reset),
    .req_vld  (req_vld),
    .grant_en (grant_take),
    .gnt_id   (gnt_id),
    .gnt_vld  (gnt_vld)
  );

  always_comb begin
    state_d = state_q;
    if (grant_take) begin
      case (win_op)
        OP_WR:   state_d = ST_W_CR;
        OP_AL:   state_d = ST_A_CR1;
        default: state_d = ST_RD_HI;
      endcase
    end else if (active) begin
      case (state_q)
        ST_RD_HI:  state_d = ST_RD_MID;
        ST_RD_MID: state_d = ST_RD_LO;
        ST_W_CR:   state_d = ST_W_HI;
        ST_W_HI:   state_d = ST_W_MID;
        ST_W_MID:  state_d = ST_W_LO;
        ST_A_CR1:  state_d = ST_A_HI;
        ST_A_HI:   state_d = ST_A_MID;
        ST_A_MID:  state_d = ST_A_LO;
        ST_A_LO:   state_d = ST_A_CR0;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // The gap only separates steps inside a burst; it is never armed by the final step
  always_comb begin
    gap_d = gap_q;
    if (clk7_en) begin
      if (active && !is_final(state_q)) begin
        gap_d = 4'(STEP_GAP);
      end else if (gap_q != 4'd0) begin
        gap_d = gap_q - 4'd1;
      end
    end
  end

  always_comb begin
    tod_sel   = 1'b0;
    tod_wr    = 1'b0;
    tod_tlo   = 1'b0;
    tod_tme   = 1'b0;
    tod_thi   = 1'b0;
    tod_tcr   = 1'b0;
    tod_wdata = 8'h00;
    if (active) begin
      tod_sel = 1'b1;
      case (state_q)
        ST_RD_HI:  tod_thi = 1'b1;
        ST_RD_MID: tod_tme = 1'b1;
        ST_RD_LO:  tod_tlo = 1'b1;
        ST_W_CR, ST_A_CR0: begin
          tod_wr = 1'b1; tod_tcr = 1'b1; tod_wdata = CR_TOD;
        end
        ST_A_CR1: begin
          tod_wr = 1'b1; tod_tcr = 1'b1; tod_wdata = CR_ALARM;
        end
        ST_W_HI, ST_A_HI: begin
          tod_wr = 1'b1; tod_thi = 1'b1; tod_wdata = req_q.wdata[23:16];
        end
        ST_W_MID, ST_A_MID: begin
          tod_wr = 1'b1; tod_tme = 1'b1; tod_wdata = req_q.wdata[15:8];
        end
        ST_W_LO, ST_A_LO: begin
          tod_wr = 1'b1; tod_tlo = 1'b1; tod_wdata = req_q.wdata[7:0];
        end
        default: tod_sel = 1'b0;
      endcase
    end
  end

  assign req_ack = (active && is_final(state_q)) ? (req_q.id ? 2'b10 : 2'b01) : 2'b00;
  assign rdata   = (active && state_q == ST_RD_LO) ? {shadow_q, tod_rdata} : rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gap_q   <= 4'd0;
      rdata_q <= 24'h0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      if (active && state_q == ST_RD_LO) begin
        rdata_q <= {shadow_q, tod_rdata};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant_take) begin
      req_q.id    <= gnt_id;
      req_q.wdata <= gnt_id ? req_wdata[47:24] : req_wdata[23:0];
    end
    if (active && state_q == ST_RD_HI)  shadow_q[15:8] <= tod_rdata;
    if (active && state_q == ST_RD_MID) shadow_q[7:0]  <= tod_rdata;
  end

endmodule

// File: tb/tb_cia_tod_seq.sv
// Directed table-driven bench for cia_tod_seq plus gap and tie-arbitration sequences.
module tb_cia_tod_seq;

  logic        clk = 1'b0;
  logic        reset, clk7_en, bus_busy;
  logic [1:0]  req_vld;
  logic [3:0]  req_op;
  logic [47:0] req_wdata;
  logic [7:0]  tod_rdata;

  logic [1:0]  ack, g_ack;
  logic [23:0] rdata, g_rdata;
  logic        sel, wr, tlo, tme, thi, tcr;
  logic        g_sel, g_wr, g_tlo, g_tme, g_thi, g_tcr;
  logic [7:0]  wdo, g_wdo;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cia_tod_seq #(.STEP_GAP(0), .FIX_PRIO(0)) dut (
    .clk(clk), .reset(reset), .clk7_en(clk7_en), .bus_busy(bus_busy),
    .req_vld(req_vld), .req_op(req_op), .req_wdata(req_wdata),
    .req_ack(ack), .rdata(rdata), .tod_sel(sel), .tod_wr(wr),
    .tod_tlo(tlo), .tod_tme(tme), .tod_thi(thi), .tod_tcr(tcr),
    .tod_wdata(wdo), .tod_rdata(tod_rdata)
  );

  cia_tod_seq #(.STEP_GAP(2), .FIX_PRIO(1)) dut_g (
    .clk(clk), .reset(reset), .clk7_en(clk7_en), .bus_busy(bus_busy),
    .req_vld(req_vld), .req_op(req_op), .req_wdata(req_wdata),
    .req_ack(g_ack), .rdata(g_rdata), .tod_sel(g_sel), .tod_wr(g_wr),
    .tod_tlo(g_tlo), .tod_tme(g_tme), .tod_thi(g_thi), .tod_tcr(g_tcr),
    .tod_wdata(g_wdo), .tod_rdata(tod_rdata)
  );

  typedef struct {
    logic        rst, en, busy;
    logic [1:0]  vld;
    logic [3:0]  op;
    logic [47:0] wd;
    logic [7:0]  trd;
    logic        sel, wr;
    logic [3:0]  rsel;   // {tcr,thi,tme,tlo}
    logic [7:0]  wdo;
    logic [1:0]  ack;
    logic [23:0] rd;
  } vec_t;

  vec_t tv[$];

  function automatic void add(input logic rst, en, busy, input logic [1:0] vld,
                              input logic [3:0] op, input logic [47:0] wd, input logic [7:0] trd,
                              input logic esel, ewr, input logic [3:0] ersel, input logic [7:0] ewdo,
                              input logic [1:0] eack, input logic [23:0] erd);
    vec_t v;
    v.rst = rst; v.en = en; v.busy = busy; v.vld = vld; v.op = op; v.wd = wd; v.trd = trd;
    v.sel = esel; v.wr = ewr; v.rsel = ersel; v.wdo = ewdo; v.ack = eack; v.rd = erd;
    tv.push_back(v);
  endfunction

  task automatic wait_g_ack(output logic [1:0] a);
    a = 2'b00;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (g_ack != 2'b00) begin
        a = g_ack;
        break;
      end
    end
  endtask

  localparam logic [47:0] WD2 = {24'hABCDEF, 24'h000000};
  localparam logic [47:0] WD3 = 48'h000000_000005;
  localparam logic [47:0] WD6 = 48'h000000_112233;

  logic [39:0] got, exp;
  logic [21:0] ggot, gexp;
  logic [21:0] gtab[13];
  logic [1:0]  tie_exp[4];
  logic [1:0]  a;

  initial begin
    // reset state and read burst
    add(0,1,0,2'b00,4'h0,48'h0,8'h00, 0,0,4'b0000,8'h00,2'b00,24'h000000);
    add(0,1,0,2'b01,4'h0,48'h0,8'h00, 0,0,4'b0000,8'h00,2'b00,24'h000000);
    add(0,1,0,2'b01,4'h0,48'h0,8'h12, 1,0,4'b0100,8'h00,2'b00,24'h000000);
    add(0,1,0,2'b01,4'h0,48'h0,8'h34, 1,0,4'b0010,8'h00,2'b00,24'h000000);
    add(0,1,0,2'b01,4'h0,48'h0,8'h56, 1,0,4'b0001,8'h00,2'b01,24'h123456);
    add(0,1,0,2'b00,4'h0,48'h0,8'h00, 0,0,4'b0000,8'h00,2'b00,24'h123456);
    // write TOD from requester 1
    add(0,1,0,2'b10,4'h4,WD2,8'h00, 0,0,4'b0000,8'h00,2'b00,24'h123456);
    add(0,1,0,2'b10,4'h4,WD2,8'h00, 1,1,4'b1000,8'h00,2'b00,24'h123456);
    add(0,1,0,2'b10,4'h4,WD2,8'h00, 1,1,4'b0100,8'hAB,2'b00,24'h123456);
    add(0,1,0,2'b10,4'h4,WD2,8'h00, 1,1,4'b0010,8'hCD,2'b00,24'h123456);
    add(0,1,0,2'b10,4'h4,WD2,8'h00, 1,1,4'b0001,8'hEF,2'b10,24'h123456);
    add(0,1,0,2'b00,4'h0,48'h0,8'h00, 0,0,4'b0000,8'h00,2'b00,24'h123456);
    // alarm write, request dropped before the closing CR write
    add(0,1,0,2'b01,4'h2,WD3,8'h00, 0,0,4'b0000,8'h00,2'b00,24'h123456);
    add(0,1,0,2'b01,4'h2,WD3,8'h00, 1,1,4'b1000,8'h80,2'b00,24'h123456);
    add(0,1,0,2'b01,4'h2,WD3,8'h00, 1,1,4'b0100,8'h00,2'b00,24'h123456);
    add(0,1,0,2'b01,4'h2,WD3,8'h00, 1,1,4'b0010,8'h00,2'b00,24'h123456);
    add(0,1,0,2'b01,4'h2,WD3,8'h00, 1,1,4'b0001,8'h05,2'b00,24'h123456);
    add(0,1,0,2'b00,4'h0,48'h0,8'h00, 1,1,4'b1000,8'h00,2'b01,24'h123456);
    add(0,1,0,2'b00,4'h0,48'h0,8'h00, 0,0,4'b0000,8'h00,2'b00,24'h123456);
    // read paused by clk7_en low and bus_busy
    add(0,1,0,2'b01,4'h0,48'h0,8'h00, 0,0,4'b0000,8'h00,2'b00,24'h123456);
    add(0,1,0,2'b01,4'h0,48'h0,8'hAA, 1,0,4'b0100,8'h00,2'b00,24'h123456);
    add(0,1,0,2'b01,4'h0,48'h0,8'hBB, 1,0,4'b0010,8'h00,2'b00,24'h123456);
    add(0,0,0,2'b01,4'h0,48'h0,8'hCC, 0,0,4'b0000,8'h00,2'b00,24'h123456);
    add(0,1,1,2'b01,4'h0,48'h0,8'hCC, 0,0,4'b0000,8'h00,2'b00,24'h123456);
    add(0,1,1,2'b01,4'h0,48'h0,8'hCC, 0,0,4'b0000,8'h00,2'b00,24'h123456);
    add(0,1,0,2'b01,4'h0,48'h0,8'hDD, 1,0,4'b0001,8'h00,2'b01,24'hAABBDD);
    add(0,1,0,2'b00,4'h0,48'h0,8'h00, 0,0,4'b0000,8'h00,2'b00,24'hAABBDD);
    // reserved op from requester 1 behaves as a read
    add(0,1,0,2'b10,4'hC,48'h0,8'h00, 0,0,4'b0000,8'h00,2'b00,24'hAABBDD);
    add(0,1,0,2'b10,4'hC,48'h0,8'h01, 1,0,4'b0100,8'h00,2'b00,24'hAABBDD);
    add(0,1,0,2'b10,4'hC,48'h0,8'h02, 1,0,4'b0010,8'h00,2'b00,24'hAABBDD);
    add(0,1,0,2'b10,4'hC,48'h0,8'h03, 1,0,4'b0001,8'h00,2'b10,24'h010203);
    add(0,1,0,2'b00,4'h0,48'h0,8'h00, 0,0,4'b0000,8'h00,2'b00,24'h010203);
    // no grant without enable, then reset in W_MID
    add(0,0,0,2'b01,4'h1,WD6,8'h00, 0,0,4'b0000,8'h00,2'b00,24'h010203);
    add(0,1,0,2'b01,4'h1,WD6,8'h00, 0,0,4'b0000,8'h00,2'b00,24'h010203);
    add(0,1,0,2'b01,4'h1,WD6,8'h00, 1,1,4'b1000,8'h00,2'b00,24'h010203);
    add(0,1,0,2'b01,4'h1,WD6,8'h00, 1,1,4'b0100,8'h11,2'b00,24'h010203);
    add(1,1,0,2'b01,4'h1,WD6,8'h00, 1,1,4'b0010,8'h22,2'b00,24'h010203);
    add(0,1,0,2'b00,4'h0,48'h0,8'h00, 0,0,4'b0000,8'h00,2'b00,24'h000000);
    add(0,1,0,2'b00,4'h0,48'h0,8'h00, 0,0,4'b0000,8'h00,2'b00,24'h000000);

    // {sel,wr,tcr,thi,tme,tlo,wdata,ack,...pad} for the STEP_GAP=2 instance
    gtab[0]  = {1'b0,1'b0,4'b0000,8'h00,2'b00,6'd0};
    gtab[1]  = {1'b1,1'b1,4'b1000,8'h00,2'b00,6'd0};
    gtab[2]  = {1'b0,1'b0,4'b0000,8'h00,2'b00,6'd0};
    gtab[3]  = {1'b0,1'b0,4'b0000,8'h00,2'b00,6'd0};
    gtab[4]  = {1'b1,1'b1,4'b0100,8'hAB,2'b00,6'd0};
    gtab[5]  = {1'b0,1'b0,4'b0000,8'h00,2'b00,6'd0};
    gtab[6]  = {1'b0,1'b0,4'b0000,8'h00,2'b00,6'd0};
    gtab[7]  = {1'b1,1'b1,4'b0010,8'hCD,2'b00,6'd0};
    gtab[8]  = {1'b0,1'b0,4'b0000,8'h00,2'b00,6'd0};
    gtab[9]  = {1'b0,1'b0,4'b0000,8'h00,2'b00,6'd0};
    gtab[10] = {1'b1,1'b1,4'b0001,8'hEF,2'b10,6'd0};
    gtab[11] = {1'b0,1'b0,4'b0000,8'h00,2'b00,6'd0};
    gtab[12] = {1'b1,1'b1,4'b1000,8'h00,2'b00,6'd0};

`ifdef CIA_TOD_SEQ_RR_EN
    tie_exp[0] = 2'b01; tie_exp[1] = 2'b10; tie_exp[2] = 2'b01; tie_exp[3] = 2'b10;
`else
    tie_exp[0] = 2'b10; tie_exp[1] = 2'b10; tie_exp[2] = 2'b10; tie_exp[3] = 2'b10;
`endif

    reset = 1'b1; clk7_en = 1'b1; bus_busy = 1'b0;
    req_vld = 2'b00; req_op = 4'h0; req_wdata = 48'h0; tod_rdata = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    foreach (tv[i]) begin
      reset = tv[i].rst; clk7_en = tv[i].en; bus_busy = tv[i].busy;
      req_vld = tv[i].vld; req_op = tv[i].op; req_wdata = tv[i].wd; tod_rdata = tv[i].trd;
      #1;
      got = {sel, wr, tcr, thi, tme, tlo, wdo, ack, rdata};
      exp = {tv[i].sel, tv[i].wr, tv[i].rsel, tv[i].wdo, tv[i].ack, tv[i].rd};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL vec%0d: got sel/wr/rsel/wdata/ack/rdata=%b/%b/%b/%h/%b/%h expected %b/%b/%b/%h/%b/%h",
                 i, sel, wr, {tcr,thi,tme,tlo}, wdo, ack, rdata,
                 tv[i].sel, tv[i].wr, tv[i].rsel, tv[i].wdo, tv[i].ack, tv[i].rd);
      end
      @(negedge clk);
    end

    // STEP_GAP=2 write burst, request held so it re-grants after one idle cycle
    reset = 1'b1; req_vld = 2'b00; clk7_en = 1'b1; bus_busy = 1'b0;
    @(negedge clk);
    reset = 1'b0; req_vld = 2'b10; req_op = 4'h4; req_wdata = WD2;
    for (int c = 0; c < 13; c++) begin
      #1;
      ggot = {g_sel, g_wr, g_tcr, g_thi, g_tme, g_tlo, g_wdo, g_ack, 6'd0};
      gexp = gtab[c];
      checks++;
      if (ggot !== gexp) begin
        errors++;
        $display("FAIL gap_c%0d: got %h expected %h", c, ggot, gexp);
      end
      @(negedge clk);
    end

    // tie arbitration with both requesters holding reads
    reset = 1'b1; req_vld = 2'b00;
    @(negedge clk);
    reset = 1'b0; req_vld = 2'b11; req_op = 4'h0; req_wdata = 48'h0;
    for (int k = 0; k < 4; k++) begin
      wait_g_ack(a);
      checks++;
      if (a !== tie_exp[k]) begin
        errors++;
        $display("FAIL tie_grant%0d: got ack %b expected %b", k, a, tie_exp[k]);
      end
    end
    req_vld = 2'b00;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
